wbu: RTL



---
 rtl/npc_pkg.sv | 59 +++++
 rtl/wbu_if.sv | 30 +++
 rtl/load_extract.sv | 39 +++
 rtl/wbu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: encodings and types shared by the NPC write-back unit.
//   wb_sel_e   : write-back source select
//   br_type_e  : branch/jump kind
//   ld_ctrl_e  : load width/extension
//   CMP_*      : three-way compare codes produced by the execute stage
//   wbu_state_e: write-back FSM states
//   wbu_req_t  : latched instruction payload
package npc_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_EXU  = 2'b01,
        WB_LOAD = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_LT   = 3'b011,
        BR_GE   = 3'b100,
        BR_JAL  = 3'b101,
        BR_JALR = 3'b110
    } br_type_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_ctrl_e;

    localparam logic [XLEN-1:0] CMP_EQ = 32'd0;
    localparam logic [XLEN-1:0] CMP_GT = 32'b10;
    localparam logic [XLEN-1:0] CMP_LT = 32'b100;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } wbu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   exu_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        wb_sel_e           wb_sel;
        br_type_e          br_type;
        ld_ctrl_e          ld_ctrl;
        logic [1:0]        addr_lo;
    } wbu_req_t;

endpackage

// File: rtl/wbu_if.sv
// wbu_if: execute-stage -> write-back handshake and instruction payload.
//   master (execute): drives in_valid and in_* fields, samples in_ready
//   slave  (wbu)    : samples in_valid and in_* fields, drives in_ready
interface wbu_if;
    import npc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_exu_data;
    logic [XLEN-1:0]   in_imm;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_wb_sel;
    logic [2:0]        in_br_type;
    logic [2:0]        in_ld_ctrl;
    logic [1:0]        in_addr_lo;

    modport master (
        output in_valid, in_pc, in_exu_data, in_imm, in_rd,
               in_wb_sel, in_br_type, in_ld_ctrl, in_addr_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_exu_data, in_imm, in_rd,
               in_wb_sel, in_br_type, in_ld_ctrl, in_addr_lo,
        output in_ready
    );

endinterface

// File: rtl/load_extract.sv
// load_extract: combinational byte/half/word select and sign/zero extension
// of a raw aligned memory word.
//   rdata_i   : raw aligned memory word
//   ld_ctrl_i : load kind (reserved encodings behave as lw)
//   addr_lo_i : byte offset; halves use addr_lo_i[1]
//   data_o    : extended load value
module load_extract
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  ld_ctrl_e        ld_ctrl_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (ld_ctrl_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LBU:  data_o = {24'd0, byte_sel};
            LD_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// wbu: write-back and branch-resolution unit. Accepts one instruction per
// handshake, waits for load data when needed, then issues one registered
// commit carrying the GPR write and the next PC.
//   clk, rst           : clock, synchronous active-high reset
//   in_if (slave)      : instruction handshake and payload
//   mem_rvalid/rdata   : load response (ignored outside WAIT_MEM)
//   gpr_wen/waddr/wdata: register-file write
//   pc_wen/pc_next     : PC update
//   commit             : one-cycle retire pulse
// Optional: `define WBU_DIFFTEST_EN adds dt_pc (PC of retiring instruction)
// and dt_retired (64-bit retire counter).
module wbu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    wbu_if.slave              in_if,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              gpr_wen,
    output logic [REG_AW-1:0] gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata,
    output logic              pc_wen,
    output logic [XLEN-1:0]   pc_next,
    output logic              commit
`ifdef WBU_DIFFTEST_EN
    ,
    output logic [XLEN-1:0]   dt_pc,
    output logic [63:0]       dt_retired
`endif
);

    wbu_state_e        state_q, state_d;
    wbu_req_t          req_q, req_d;
    wbu_req_t          in_req, src;
    logic              gpr_wen_q, gpr_wen_d;
    logic [REG_AW-1:0] gpr_waddr_q, gpr_waddr_d;
    logic [XLEN-1:0]   gpr_wdata_q, gpr_wdata_d;
    logic              pc_wen_q, pc_wen_d;
    logic [XLEN-1:0]   pc_next_q, pc_next_d;
    logic              commit_q, commit_d;
    logic [XLEN-1:0]   ld_data_c, wb_data_c, npc_c;
    logic              taken_c;
    logic              go_commit_c;

    assign in_req = '{
        pc:       in_if.in_pc,
        exu_data: in_if.in_exu_data,
        imm:      in_if.in_imm,
        rd:       in_if.in_rd,
        wb_sel:   wb_sel_e'(in_if.in_wb_sel),
        br_type:  br_type_e'(in_if.in_br_type),
        ld_ctrl:  ld_ctrl_e'(in_if.in_ld_ctrl),
        addr_lo:  in_if.in_addr_lo
    };

    // Commit results are computed from the live inputs when a non-load is
    // accepted, so the commit registers load on the accept edge.
    assign src = (state_q == S_IDLE) ? in_req : req_q;

    assign in_if.in_ready = (state_q == S_IDLE);

    load_extract u_load_extract (
        .rdata_i   (mem_rdata),
        .ld_ctrl_i (src.ld_ctrl),
        .addr_lo_i (src.addr_lo),
        .data_o    (ld_data_c)
    );

    // Write-back data select
    always_comb begin
        case (src.wb_sel)
            WB_EXU:  wb_data_c = src.exu_data;
            WB_LOAD: wb_data_c = ld_data_c;
            WB_PC4:  wb_data_c = src.pc + 32'd4;
            default: wb_data_c = '0;
        endcase
    end

    // Branch resolution; unknown compare codes read as not-equal
    always_comb begin
        case (src.br_type)
            BR_EQ:   taken_c = (src.exu_data == CMP_EQ);
            BR_NE:   taken_c = (src.exu_data != CMP_EQ);
            BR_LT:   taken_c = (src.exu_data == CMP_LT);
            BR_GE:   taken_c = (src.exu_data != CMP_LT);
            BR_JAL:  taken_c = 1'b1;
            default: taken_c = 1'b0;
        endcase
        if (src.br_type == BR_JALR) begin
            npc_c = src.exu_data & ~32'd1;
        end else if (taken_c) begin
            npc_c = src.pc + src.imm;
        end else begin
            npc_c = src.pc + 32'd4;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        gpr_wen_d   = 1'b0;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        pc_wen_d    = 1'b0;
        pc_next_d   = pc_next_q;
        commit_d    = 1'b0;
        go_commit_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid) begin
                    req_d = in_req;
                    if (in_req.wb_sel == WB_LOAD) begin
                        state_d = S_WAIT_MEM;
                    end else begin
                        state_d     = S_COMMIT;
                        go_commit_c = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d     = S_COMMIT;
                    go_commit_c = 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (go_commit_c) begin
            gpr_wen_d   = (src.wb_sel != WB_NONE) && (src.rd != '0);
            gpr_waddr_d = src.rd;
            gpr_wdata_d = wb_data_c;
            pc_wen_d    = 1'b1;
            pc_next_d   = npc_c;
            commit_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
            pc_wen_q    <= 1'b0;
            pc_next_q   <= RESET_PC;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
            pc_wen_q    <= pc_wen_d;
            pc_next_q   <= pc_next_d;
            commit_q    <= commit_d;
        end
    end

    assign gpr_wen   = gpr_wen_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;
    assign pc_wen    = pc_wen_q;
    assign pc_next   = pc_next_q;
    assign commit    = commit_q;

`ifdef WBU_DIFFTEST_EN
    logic [XLEN-1:0] dt_pc_q;
    logic [63:0]     dt_retired_q;

    // Counter advances as each commit pulse retires
    always_ff @(posedge clk) begin
        if (rst) begin
            dt_pc_q      <= '0;
            dt_retired_q <= '0;
        end else begin
            if (go_commit_c) begin
                dt_pc_q <= src.pc;
            end
            if (commit_q) begin
                dt_retired_q <= dt_retired_q + 64'd1;
            end
        end
    end

    assign dt_pc      = dt_pc_q;
    assign dt_retired = dt_retired_q;
`endif

endmodule
